musb_mem_arbiter: RTL and testbench
===================================

Name: musb_mem_arbiter

Overview:
- Shares one single-ported memory/bus slave between the musb_core instruction port (iport) and data port (dport).
- Round-robin arbitration; registers each granted request and drives one memory transaction at a time.
- Returns the response to the owning port as a one-cycle ready or error pulse.
- Bus-side watchdog ends hung transactions with an error.
- Sits between the core and a single-port memory or bus interconnect; the dual-port memory model is not needed.

Parameters:
- TIMEOUT_CYCLES, 255: BUSY cycles without mem_ready/mem_error before forced error; range 1..255; 8-bit counter.
- ADDR_WIDTH, 32: width of port and memory addresses.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- iport_address  in  ADDR_WIDTH  instruction request address
- iport_wr  in  4  instruction byte write enables (normally 0)
- iport_enable  in  1  instruction request; held until iport_ready or iport_error
- iport_data_i  out  32  instruction read data
- iport_ready  out  1  instruction completion pulse
- iport_error  out  1  instruction error pulse
- dport_address  in  ADDR_WIDTH  data request address
- dport_data_o  in  32  data write data
- dport_wr  in  4  data byte write enables; 0 = read
- dport_enable  in  1  data request; held until dport_ready or dport_error
- dport_data_i  out  32  data read data
- dport_ready  out  1  data completion pulse
- dport_error  out  1  data error pulse
- mem_address  out  ADDR_WIDTH  memory address
- mem_data_o  out  32  memory write data
- mem_wr  out  4  memory byte enables
- mem_enable  out  1  memory request, held until mem_ready/mem_error
- mem_data_i  in  32  memory read data
- mem_ready  in  1  memory completion
- mem_error  in  1  memory error

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; owner=I; last_grant=I; timeout counter 0.
  - Reset in any state returns to IDLE next cycle, drops mem_enable and pulses nothing; an in-flight transaction is abandoned.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples the enables. Only iport_enable → owner=I. Only dport_enable → owner=D.
  - Both asserted → owner = port opposite last_grant; last_grant <= owner.
  - Latch the owner's address, wr and write data (iport write data = 0); clear counter; go to BUSY.
  - No request → stay in IDLE.
- BUSY:
  - mem_enable=1; mem_address, mem_wr, mem_data_o come from the latched registers and are stable for the whole state.
  - mem_ready=1 → latch mem_data_i, set resp_err=0, go to RESP.
  - mem_error=1 (priority over mem_ready) → resp_err=1, data 0, go to RESP.
  - Otherwise increment counter; at counter==TIMEOUT_CYCLES-1 with no ready/error → resp_err=1, data 0, go to RESP.
- RESP:
  - mem_enable=0.
  - Owner's ready=!resp_err and error=resp_err, high exactly one cycle.
  - Owner's data_i = latched data; held until that port's next response, never changed by the other port's transactions.
  - Non-owner outputs unchanged and not pulsed. Go to IDLE.
- Latency: minimum 3 cycles from enable sampled to ready pulse (IDLE, BUSY with immediate mem_ready, RESP); each extra memory wait adds 1.
- No pipelining: back-to-back requests from one port are separated by one IDLE cycle. The requester drops or updates enable on the edge ending RESP, so IDLE sees only the new request and no request is issued twice.
- Owner drops enable during BUSY: the memory transaction still completes (not abortable); the RESP pulse is suppressed; last_grant is already updated.
- Fairness: under continuous contention, grants alternate I,D,I,D; neither port waits more than one other transaction.
- The other port's enable is ignored outside IDLE; that request waits.
- mem_ready/mem_error outside BUSY are ignored.

Test Plan:
- Reset, then iport_enable=1, address 0x0000_0100, memory answers ready in first BUSY cycle with data 0x2402_0005 → mem_enable high 1 cycle at address 0x100, mem_wr=0; iport_ready pulses 1 cycle, 3 cycles after enable sampled; iport_data_i=0x2402_0005; dport outputs stay 0.
- dport write: address 0x40, data 0xDEAD_BEEF, wr=4'b0011, memory waits 2 cycles → mem_* held stable 3 BUSY cycles; dport_ready at cycle 5; iport_ready never pulses.
- Both enables held high continuously from reset, 6 transactions → grant order D,I,D,I,D,I; each port gets 3 ready pulses.
- TIMEOUT_CYCLES=4, dport read, memory never responds → mem_enable high exactly 4 cycles; dport_error pulses once, dport_ready=0, dport_data_i=0; arbiter then returns to IDLE and serves a pending iport request.
- mem_error and mem_ready together on an iport fetch → iport_error=1, iport_ready=0, iport_data_i=0.
- rst asserted in second BUSY cycle → next cycle mem_enable=0, no ready/error pulse; after release a held iport request is re-issued from IDLE.

Source files
------------

// File: rtl/musb_mem_arbiter_if.sv
// Bundle of the instruction port, data port and single memory port around musb_mem_arbiter.
// slave is the arbiter's view; master is the view of the core ports and memory around it.
interface musb_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] iport_address;
    logic [3:0]            iport_wr;
    logic                  iport_enable;
    logic [31:0]           iport_data_i;
    logic                  iport_ready;
    logic                  iport_error;

    logic [ADDR_WIDTH-1:0] dport_address;
    logic [31:0]           dport_data_o;
    logic [3:0]            dport_wr;
    logic                  dport_enable;
    logic [31:0]           dport_data_i;
    logic                  dport_ready;
    logic                  dport_error;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_o;
    logic [3:0]            mem_wr;
    logic                  mem_enable;
    logic [31:0]           mem_data_i;
    logic                  mem_ready;
    logic                  mem_error;

    modport slave (
        input  iport_address, iport_wr, iport_enable,
        output iport_data_i, iport_ready, iport_error,
        input  dport_address, dport_data_o, dport_wr, dport_enable,
        output dport_data_i, dport_ready, dport_error,
        output mem_address, mem_data_o, mem_wr, mem_enable,
        input  mem_data_i, mem_ready, mem_error
    );

    modport master (
        output iport_address, iport_wr, iport_enable,
        input  iport_data_i, iport_ready, iport_error,
        output dport_address, dport_data_o, dport_wr, dport_enable,
        input  dport_data_i, dport_ready, dport_error,
        input  mem_address, mem_data_o, mem_wr, mem_enable,
        output mem_data_i, mem_ready, mem_error
    );
endinterface

// File: rtl/musb_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the musb instruction and data ports,
// with a bus-side watchdog that ends hung transactions with an error.
module musb_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,  // 1..255
    parameter int          ADDR_WIDTH     = 32
) (
    input  logic                clk,
    input  logic                rst,
    musb_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;            // 0 = iport, 1 = dport
    logic                  last_grant_q, last_grant_d;
    logic [7:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wr_q, wr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  mem_enable_q, mem_enable_d;
    logic                  dropped_q, dropped_d;
    logic [31:0]           idata_q, idata_d;
    logic [31:0]           ddata_q, ddata_d;
    logic                  iready_q, iready_d;
    logic                  ierror_q, ierror_d;
    logic                  dready_q, dready_d;
    logic                  derror_q, derror_d;

    logic                  owner_en;
    logic                  resp_err;
    logic [31:0]           resp_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        mem_enable_d = mem_enable_q;
        dropped_d    = dropped_q;
        idata_d      = idata_q;
        ddata_d      = ddata_q;
        iready_d     = 1'b0;
        ierror_d     = 1'b0;
        dready_d     = 1'b0;
        derror_d     = 1'b0;
        owner_en     = 1'b0;
        resp_err     = 1'b0;
        resp_data    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.iport_enable || bus.dport_enable) begin
                    // last_grant only moves on contention, so a lone request never skews the rotation
                    if (bus.iport_enable && bus.dport_enable) begin
                        owner_d      = ~last_grant_q;
                        last_grant_d = ~last_grant_q;
                    end else begin
                        owner_d = bus.dport_enable;
                    end
                    if (owner_d) begin
                        addr_d  = bus.dport_address;
                        wr_d    = bus.dport_wr;
                        wdata_d = bus.dport_data_o;
                    end else begin
                        addr_d  = bus.iport_address;
                        wr_d    = bus.iport_wr;
                        wdata_d = '0;
                    end
                    count_d      = '0;
                    dropped_d    = 1'b0;
                    mem_enable_d = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                owner_en  = owner_q ? bus.dport_enable : bus.iport_enable;
                dropped_d = dropped_q | ~owner_en;
                if (bus.mem_error || bus.mem_ready || count_q == LAST_COUNT) begin
                    resp_err     = bus.mem_error || !bus.mem_ready;
                    resp_data    = resp_err ? '0 : bus.mem_data_i;
                    mem_enable_d = 1'b0;
                    state_d      = RESP;
                    // an abandoned request still lets memory finish but gets no pulse or data
                    if (!dropped_d) begin
                        if (owner_q) begin
                            ddata_d  = resp_data;
                            dready_d = !resp_err;
                            derror_d = resp_err;
                        end else begin
                            idata_d  = resp_data;
                            iready_d = !resp_err;
                            ierror_d = resp_err;
                        end
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            count_q      <= '0;
            addr_q       <= '0;
            wr_q         <= '0;
            wdata_q      <= '0;
            mem_enable_q <= 1'b0;
            dropped_q    <= 1'b0;
            idata_q      <= '0;
            ddata_q      <= '0;
            iready_q     <= 1'b0;
            ierror_q     <= 1'b0;
            dready_q     <= 1'b0;
            derror_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            mem_enable_q <= mem_enable_d;
            dropped_q    <= dropped_d;
            idata_q      <= idata_d;
            ddata_q      <= ddata_d;
            iready_q     <= iready_d;
            ierror_q     <= ierror_d;
            dready_q     <= dready_d;
            derror_q     <= derror_d;
        end
    end

    assign bus.mem_address  = addr_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_data_o   = wdata_q;
    assign bus.mem_enable   = mem_enable_q;
    assign bus.iport_data_i = idata_q;
    assign bus.iport_ready  = iready_q;
    assign bus.iport_error  = ierror_q;
    assign bus.dport_data_i = ddata_q;
    assign bus.dport_ready  = dready_q;
    assign bus.dport_error  = derror_q;
endmodule

// File: tb/tb_musb_mem_arbiter.sv
// Bench for musb_mem_arbiter: directed vectors, corner sequences and random traffic
// checked every cycle against a transaction-level model of the arbiter and memory.
module tb_musb_mem_arbiter;
    localparam int unsigned TO      = 4;
    localparam int unsigned M_READY = 0;
    localparam int unsigned M_ERR   = 1;
    localparam int unsigned M_BOTH  = 2;
    localparam int unsigned M_NONE  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    musb_mem_arbiter_if #(.ADDR_WIDTH(32)) bus_if ();
    musb_mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    // memory behaviour: forced per directed test, random otherwise
    bit use_forced, spur;
    int unsigned f_wait, f_mode;
    logic [31:0] f_rdata;

    // transaction-level model: phase 0 idle, 1 memory in flight, 2 response cycle
    int unsigned ph, k, m_wait, m_mode;
    bit m_owner, m_last, m_drop, m_done, m_resp_err;
    logic [31:0] m_addr, m_wdata, m_rdata, m_resp_data, m_idata, m_ddata;
    logic [3:0]  m_wr;
    logic p_rst, p_ien, p_den;
    logic [31:0] p_iaddr, p_daddr, p_dwd;
    logic [3:0]  p_iwr, p_dwr;

    bit i_act, d_act;
    int unsigned i_age, d_age;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int unsigned r;
        bit resp;
        p_rst = rst;
        p_ien = bus_if.iport_enable;  p_den = bus_if.dport_enable;
        p_iaddr = bus_if.iport_address; p_iwr = bus_if.iport_wr;
        p_daddr = bus_if.dport_address; p_dwr = bus_if.dport_wr; p_dwd = bus_if.dport_data_o;
        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            ph = 0; m_last = 1'b0; m_idata = '0; m_ddata = '0;
        end else if (ph == 0) begin
            if (p_ien || p_den) begin
                if (p_ien && p_den) begin
                    m_owner = !m_last;
                    m_last  = m_owner;
                end else begin
                    m_owner = p_den;
                end
                if (m_owner) begin
                    m_addr = p_daddr; m_wr = p_dwr; m_wdata = p_dwd;
                end else begin
                    m_addr = p_iaddr; m_wr = p_iwr; m_wdata = '0;
                end
                if (use_forced) begin
                    m_wait = f_wait; m_mode = f_mode; m_rdata = f_rdata;
                end else begin
                    m_wait = $urandom_range(0, 5);
                    r = $urandom_range(0, 9);
                    m_mode = (r == 0) ? M_ERR : (r == 1) ? M_BOTH : (r == 2) ? M_NONE : M_READY;
                    m_rdata = $urandom;
                end
                k = 0; m_drop = 1'b0; ph = 1;
            end
        end else if (ph == 1) begin
            if ((m_owner ? p_den : p_ien) == 1'b0) m_drop = 1'b1;
            if (m_done) ph = 2;
            else k++;
        end else begin
            ph = 0;
        end

        chk("mem_enable", 32'(bus_if.mem_enable), 32'(ph == 1));
        if (ph == 1) begin
            chk("mem_address", bus_if.mem_address, m_addr);
            chk("mem_wr", 32'(bus_if.mem_wr), 32'(m_wr));
            chk("mem_data_o", bus_if.mem_data_o, m_wdata);
        end
        resp = (ph == 2) && !m_drop;
        if (resp) begin
            if (m_owner) m_ddata = m_resp_data;
            else m_idata = m_resp_data;
        end
        chk("iport_ready", 32'(bus_if.iport_ready), 32'(resp && !m_owner && !m_resp_err));
        chk("iport_error", 32'(bus_if.iport_error), 32'(resp && !m_owner && m_resp_err));
        chk("dport_ready", 32'(bus_if.dport_ready), 32'(resp && m_owner && !m_resp_err));
        chk("dport_error", 32'(bus_if.dport_error), 32'(resp && m_owner && m_resp_err));
        chk("iport_data_i", bus_if.iport_data_i, m_idata);
        chk("dport_data_i", bus_if.dport_data_i, m_ddata);

        m_done = 1'b0;
        bus_if.mem_ready = 1'b0; bus_if.mem_error = 1'b0; bus_if.mem_data_i = $urandom;
        if (ph == 1) begin
            if (m_mode != M_NONE && k == m_wait && m_wait < TO) begin
                bus_if.mem_ready  = (m_mode == M_READY) || (m_mode == M_BOTH);
                bus_if.mem_error  = (m_mode == M_ERR) || (m_mode == M_BOTH);
                bus_if.mem_data_i = m_rdata;
                m_done = 1'b1;
                m_resp_err  = bus_if.mem_error;
                m_resp_data = m_resp_err ? '0 : m_rdata;
            end else if (k == TO - 1) begin
                m_done = 1'b1; m_resp_err = 1'b1; m_resp_data = '0;
            end
        end else if (spur && $urandom_range(0, 3) == 0) begin
            bus_if.mem_ready = 1'($urandom);
            bus_if.mem_error = 1'($urandom);
        end
    endtask

    task automatic rand_drive();
        if (i_act && (bus_if.iport_ready || bus_if.iport_error)) i_act = 1'b0;
        if (d_act && (bus_if.dport_ready || bus_if.dport_error)) d_act = 1'b0;
        if (i_act) begin
            i_age++;
            if (i_age > 40) begin
                checks++; errors++;
                $display("FAIL iport_watchdog cyc=%0d actual=no_response required=response", cyc);
                i_act = 1'b0;
            end
        end
        if (d_act) begin
            d_age++;
            if (d_age > 40) begin
                checks++; errors++;
                $display("FAIL dport_watchdog cyc=%0d actual=no_response required=response", cyc);
                d_act = 1'b0;
            end
        end
        if (!i_act && $urandom_range(0, 2) != 0) begin
            i_act = 1'b1; i_age = 0;
            bus_if.iport_address = $urandom;
            bus_if.iport_wr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
        end
        if (!d_act && $urandom_range(0, 2) != 0) begin
            d_act = 1'b1; d_age = 0;
            bus_if.dport_address = $urandom;
            bus_if.dport_wr = 4'($urandom);
            bus_if.dport_data_o = $urandom;
        end
        bus_if.iport_enable = i_act;
        bus_if.dport_enable = d_act;
    endtask

    typedef struct {
        bit          dport;
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] wdata;
        int unsigned wt;
        int unsigned mode;
        logic [31:0] rdata;
        bit          e_ready;
        bit          e_error;
        logic [31:0] e_data;
        int unsigned e_lat;
        int unsigned e_mcyc;
    } vec_t;

    initial begin
        vec_t vt[7];
        int unsigned t0, mcyc, n_resp, pulses, derr_cyc, icyc;
        bit got;
        bit order[6];

        vt[0] = '{1'b0, 32'h0000_0100, 4'h0, 32'h0, 0, M_READY, 32'h2402_0005, 1'b1, 1'b0, 32'h2402_0005, 2, 1};
        vt[1] = '{1'b1, 32'h0000_0040, 4'h3, 32'hDEAD_BEEF, 2, M_READY, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_1234, 4, 3};
        vt[2] = '{1'b1, 32'h0000_0080, 4'h0, 32'h0, 0, M_NONE, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0, 5, 4};
        vt[3] = '{1'b0, 32'h0000_0104, 4'h0, 32'h0, 0, M_BOTH, 32'h1111_2222, 1'b0, 1'b1, 32'h0, 2, 1};
        vt[4] = '{1'b0, 32'h0000_0108, 4'h0, 32'h0, 3, M_READY, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0BAD_F00D, 5, 4};
        vt[5] = '{1'b1, 32'h0000_00C0, 4'hF, 32'hCAFE_F00D, 1, M_ERR, 32'h7777_7777, 1'b0, 1'b1, 32'h0, 3, 2};
        vt[6] = '{1'b1, 32'h0000_0044, 4'h0, 32'h0, 5, M_READY, 32'h9999_0000, 1'b0, 1'b1, 32'h0, 5, 4};

        rst = 1'b1;
        bus_if.iport_address = '0; bus_if.iport_wr = '0; bus_if.iport_enable = 1'b0;
        bus_if.dport_address = '0; bus_if.dport_wr = '0; bus_if.dport_enable = 1'b0;
        bus_if.dport_data_o = '0;
        bus_if.mem_data_i = '0; bus_if.mem_ready = 1'b0; bus_if.mem_error = 1'b0;
        use_forced = 1'b1; spur = 1'b0; f_wait = 0; f_mode = M_READY; f_rdata = '0;
        ph = 0; k = 0; m_owner = 1'b0; m_last = 1'b0; m_drop = 1'b0; m_done = 1'b0;
        m_resp_err = 1'b0; m_resp_data = '0; m_idata = '0; m_ddata = '0;
        m_addr = '0; m_wr = '0; m_wdata = '0; m_rdata = '0; m_wait = 0; m_mode = 0;
        i_act = 1'b0; d_act = 1'b0; i_age = 0; d_age = 0;

        step(); step(); rst = 1'b0; step(); step();

        // directed single transactions
        for (int v = 0; v < 7; v++) begin
            f_wait = vt[v].wt; f_mode = vt[v].mode; f_rdata = vt[v].rdata;
            if (vt[v].dport) begin
                bus_if.dport_address = vt[v].addr; bus_if.dport_wr = vt[v].wr;
                bus_if.dport_data_o = vt[v].wdata; bus_if.dport_enable = 1'b1;
            end else begin
                bus_if.iport_address = vt[v].addr; bus_if.iport_wr = vt[v].wr;
                bus_if.iport_enable = 1'b1;
            end
            t0 = cyc; got = 1'b0; mcyc = 0;
            for (int n = 0; n < 20 && !got; n++) begin
                step();
                if (bus_if.mem_enable) mcyc++;
                if (vt[v].dport ? (bus_if.dport_ready || bus_if.dport_error)
                                : (bus_if.iport_ready || bus_if.iport_error)) begin
                    got = 1'b1;
                    chk($sformatf("v%0d_ready", v), 32'(vt[v].dport ? bus_if.dport_ready : bus_if.iport_ready), 32'(vt[v].e_ready));
                    chk($sformatf("v%0d_error", v), 32'(vt[v].dport ? bus_if.dport_error : bus_if.iport_error), 32'(vt[v].e_error));
                    chk($sformatf("v%0d_data", v), vt[v].dport ? bus_if.dport_data_i : bus_if.iport_data_i, vt[v].e_data);
                    chk($sformatf("v%0d_latency", v), cyc - t0, vt[v].e_lat);
                    chk($sformatf("v%0d_mem_cycles", v), mcyc, vt[v].e_mcyc);
                    bus_if.iport_enable = 1'b0; bus_if.dport_enable = 1'b0;
                end
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL v%0d_response cyc=%0d actual=none required=pulse", v, cyc);
            end
            bus_if.iport_enable = 1'b0; bus_if.dport_enable = 1'b0;
            step();
            chk($sformatf("v%0d_pulse_width", v),
                32'({bus_if.iport_ready, bus_if.iport_error, bus_if.dport_ready, bus_if.dport_error}), 32'h0);
            step();
        end

        // continuous contention from reset: D,I,D,I,D,I
        rst = 1'b1; f_mode = M_READY; f_wait = 1; f_rdata = 32'h4444_0000;
        bus_if.iport_address = 32'h1000; bus_if.iport_wr = '0; bus_if.iport_enable = 1'b1;
        bus_if.dport_address = 32'h2000; bus_if.dport_wr = '0; bus_if.dport_enable = 1'b1;
        step(); rst = 1'b0;
        n_resp = 0;
        for (int n = 0; n < 60 && n_resp < 6; n++) begin
            step();
            if (bus_if.iport_ready) begin
                order[n_resp] = 1'b0; n_resp++;
                bus_if.iport_address = bus_if.iport_address + 32'd4;
            end
            if (bus_if.dport_ready) begin
                order[n_resp] = 1'b1; n_resp++;
                bus_if.dport_address = bus_if.dport_address + 32'd4;
            end
        end
        chk("contention_count", n_resp, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < int'(n_resp)) chk($sformatf("grant_order_%0d", i), 32'(order[i]), 32'((i % 2) == 0));
        end
        bus_if.iport_enable = 1'b0; bus_if.dport_enable = 1'b0;
        step(); step();

        // reset in the second BUSY cycle, then the held iport request is re-issued
        f_mode = M_NONE; f_wait = 0;
        bus_if.iport_address = 32'h300; bus_if.iport_wr = '0; bus_if.iport_enable = 1'b1;
        t0 = cyc;
        step(); step();
        chk("rst_busy2_men", 32'(bus_if.mem_enable), 32'h1);
        rst = 1'b1; f_mode = M_READY; f_wait = 0; f_rdata = 32'h600D_0001;
        step();
        chk("rst_men_dropped", 32'(bus_if.mem_enable), 32'h0);
        chk("rst_no_pulse", 32'({bus_if.iport_ready, bus_if.iport_error}), 32'h0);
        rst = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (bus_if.iport_ready) begin
                got = 1'b1;
                chk("rst_reissue_cyc", cyc - t0, 5);
                chk("rst_reissue_data", bus_if.iport_data_i, 32'h600D_0001);
                bus_if.iport_enable = 1'b0;
            end
        end
        chk("rst_reissue_seen", 32'(got), 32'h1);
        bus_if.iport_enable = 1'b0;
        step(); step();

        // owner abandons its request during BUSY: memory completes, no pulse
        f_mode = M_READY; f_wait = 2; f_rdata = 32'hABCD_0000;
        bus_if.iport_address = 32'h400; bus_if.iport_enable = 1'b1;
        step();
        bus_if.iport_enable = 1'b0;
        mcyc = 32'(bus_if.mem_enable); pulses = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (bus_if.mem_enable) mcyc++;
            if (bus_if.iport_ready || bus_if.iport_error) pulses++;
        end
        chk("drop_no_pulse", pulses, 0);
        chk("drop_mem_cycles", mcyc, 3);

        // dport times out while an iport request waits, then iport is served
        f_mode = M_NONE; f_wait = 0;
        bus_if.dport_address = 32'h500; bus_if.dport_wr = '0; bus_if.dport_enable = 1'b1;
        t0 = cyc;
        step();
        bus_if.iport_address = 32'h600; bus_if.iport_wr = '0; bus_if.iport_enable = 1'b1;
        f_mode = M_READY; f_wait = 1; f_rdata = 32'h1357_9BDF;
        derr_cyc = 0; icyc = 0; got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            if (bus_if.dport_error) begin derr_cyc = cyc - t0; bus_if.dport_enable = 1'b0; end
            if (bus_if.iport_ready) begin
                got = 1'b1; icyc = cyc - t0; bus_if.iport_enable = 1'b0;
                chk("pend_iport_data", bus_if.iport_data_i, 32'h1357_9BDF);
            end
        end
        chk("pend_dport_error_cyc", derr_cyc, 5);
        chk("pend_iport_ready_cyc", icyc, 9);
        bus_if.iport_enable = 1'b0; bus_if.dport_enable = 1'b0;
        step(); step();

        // random traffic with spurious memory strobes outside transactions
        use_forced = 1'b0; spur = 1'b1;
        rand_drive();
        for (int n = 0; n < 3000; n++) begin
            step();
            rand_drive();
        end
        bus_if.iport_enable = 1'b0; bus_if.dport_enable = 1'b0; spur = 1'b0;
        for (int n = 0; n < 8; n++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
